alt_vipvfr131_common_cdc_tx_ctrl: RTL
=====================================

# alt_vipvfr131_common_cdc_tx_ctrl

Source-side controller for a toggle request/acknowledge word transfer into another clock domain. It captures one WIDTH-bit word and holds it stable on `xfer_data`, toggles `xfer_req`, and waits for the far domain to return the matching `xfer_ack_async` toggle. That acknowledge passes through an internal 2-stage reset-clearing synchronizer. The block sits beside the frame reader's register/control path and sequences every multi-bit control crossing, so the far side only ever sees the single-bit `xfer_req` cross asynchronously.

## Interface
Parameters:
- `WIDTH`, 32, width of the transferred word.
- `CLOCKS_ARE_SAME`, 0, 1 = both domains share one clock; `xfer_ack_async` is used unsynchronized.
- `TIMEOUT_CYCLES`, 1023, cycles allowed in WAIT_ACK before fault; 0 disables timeout.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `send_valid`  in  1  request to transfer `send_data`.
- `send_data`  in  WIDTH  word to transfer.
- `send_ready`  out  1  high only in IDLE; a transfer is accepted when `send_valid && send_ready`.
- `xfer_req`  out  1  request toggle level to the far domain; registered.
- `xfer_data`  out  WIDTH  captured word; registered; changes only on acceptance.
- `xfer_ack_async`  in  1  acknowledge toggle from the far domain.
- `busy`  out  1  high in WAIT_ACK and FAULT.
- `done`  out  1  one-cycle pulse when a transfer is acknowledged.
- `timeout`  out  1  one-cycle pulse on entry to FAULT.
- `fault`  out  1  level, high in FAULT.

## Operation
- Acknowledge synchronizer:
  - `ack_s0 <= xfer_ack_async`, `ack_s1 <= ack_s0`.
  - Both flops clear on reset.
  - `ack = ack_s1` when `CLOCKS_ARE_SAME=0`; `ack = xfer_ack_async` when `CLOCKS_ARE_SAME=1`.
- `match = (ack == xfer_req)`.
- The FSM has three states:
  - **IDLE**
    - `send_ready=1`.
    - On acceptance: `xfer_data <= send_data`, `xfer_req <= ~xfer_req`, `cnt <= 0`, go to WAIT_ACK.
  - **WAIT_ACK**
    - If `match`: `done <= 1`, go to IDLE.
    - Else if `TIMEOUT_CYCLES != 0` and `cnt == TIMEOUT_CYCLES-1`: `timeout <= 1`, go to FAULT.
    - Else `cnt <= cnt+1`.
    - `match` has priority over timeout on the same cycle.
  - **FAULT**
    - `send_ready=0`, `fault=1`.
    - Waits for a late ack; when `match`, go to IDLE without a `done` pulse.
    - No new transfer is accepted until the toggle pair is realigned.
- `cnt` is `$clog2(TIMEOUT_CYCLES+1)` bits wide. It never wraps: it stops advancing on state exit.
- `send_valid` while not ready is ignored. `send_data` is not sampled outside acceptance.
- Reset values: all outputs 0, state IDLE.
  - `send_ready` is 1 combinationally in IDLE, so it reads 1 during and right after reset.
- Reset mid-transfer: state returns to IDLE and `xfer_req` returns to 0. The far side must be reset in the same event; the toggle pair is then aligned at 0/0.

## Timing
- Acceptance at edge T: `xfer_req` and `xfer_data` update at T; `busy=1` from T.
- Ack toggle latency:
  - `CLOCKS_ARE_SAME=0`: if `xfer_ack_async` changes before edge k, `ack_s1` updates at k+1, and at edge k+2 the state returns to IDLE with `done=1`. `send_ready=1` in that same cycle.
  - `CLOCKS_ARE_SAME=1`: the transition occurs at edge k.
- Back-to-back: a new acceptance is possible in the `done` cycle. Minimum transfer period (`CLOCKS_ARE_SAME=0`, far side acks immediately) is 4 cycles.
- Timeout: with no ack, `timeout` pulses and `fault` rises exactly `TIMEOUT_CYCLES` edges after the acceptance edge.
- `xfer_data` is stable from acceptance through the `done` cycle, and through FAULT until realignment.

## Test plan
- **Basic transfer:** reset, `send_data=32'hA5A5_0001`, `send_valid` for 1 cycle; bench flips ack 5 cycles later → `xfer_req` 0→1 at acceptance, `xfer_data=A5A5_0001`, `done` pulses exactly 2 edges after the ack change, `busy` low after.
- **Back-to-back:** hold `send_valid` high with words 1, 2, 3 and an immediate-ack far model → three `done` pulses, `xfer_req` toggles 1,0,1, period 4 cycles, each word held until its `done`.
- **Timeout with `TIMEOUT_CYCLES=8`:** no ack → `timeout` pulse and `fault=1` 8 edges after acceptance, `send_ready=0`. Ack flip 20 cycles later → `fault` clears 2 edges after the flip, no `done`, `send_ready=1`.
- **Priority/boundary with `TIMEOUT_CYCLES=8`:** ack arranged so `match` first holds at `cnt==7` → `done=1`, `timeout=0`. With `TIMEOUT_CYCLES=0` and no ack for 5000 cycles → no timeout, `busy` stays high.
- **Reset mid-transfer:** assert `reset` in WAIT_ACK with `xfer_req=1` → next cycle all outputs 0 except `send_ready=1`; a new transfer then completes normally.
- **`CLOCKS_ARE_SAME=1`:** same as the basic transfer → `done` at the edge where the ack change is sampled (0 sync latency).

Source files
------------

// File: rtl/alt_vipvfr131_common_cdc_tx_ctrl.sv
// Source-side controller for a toggle request/acknowledge word crossing.
// Holds the captured word on xfer_data while the far domain returns the xfer_req toggle.
module alt_vipvfr131_common_cdc_tx_ctrl #(
  parameter int WIDTH           = 32,
  parameter int CLOCKS_ARE_SAME = 0,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             send_valid,
  input  logic [WIDTH-1:0] send_data,
  output logic             send_ready,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack_async,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ack_s0;
  logic             r_ack_s1;
  logic             r_xfer_req;
  logic [WIDTH-1:0] r_xfer_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_timeout;

  logic w_ack;
  logic w_match;
  logic w_accept;
  logic w_cnt_last;
  logic w_cnt_inc;
  logic w_done_next;
  logic w_timeout_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack_s0 <= 1'b0;
      r_ack_s1 <= 1'b0;
    end else begin
      r_ack_s0 <= xfer_ack_async;
      r_ack_s1 <= r_ack_s0;
    end
  end

  // A shared clock lets the acknowledge be used directly, removing two cycles of latency.
  assign w_ack      = (CLOCKS_ARE_SAME != 0) ? xfer_ack_async : r_ack_s1;
  assign w_match    = (w_ack == r_xfer_req);
  assign w_accept   = send_valid && send_ready;
  assign w_cnt_last = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_done_next    = 1'b0;
    w_timeout_next = 1'b0;
    w_cnt_inc      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (w_match) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else if (w_cnt_last) begin
          w_state_next   = ST_FAULT;
          w_timeout_next = 1'b1;
        end else begin
          // With the timeout disabled the counter is frozen so it can never wrap.
          w_cnt_inc = (TIMEOUT_CYCLES != 0);
        end
      end
      ST_FAULT: begin
        if (w_match) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    send_ready = (r_state == ST_IDLE);
    busy       = (r_state == ST_WAIT_ACK) || (r_state == ST_FAULT);
    fault      = (r_state == ST_FAULT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_xfer_req  <= 1'b0;
      r_xfer_data <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done    <= w_done_next;
      r_timeout <= w_timeout_next;
      if (w_accept) begin
        r_xfer_req  <= ~r_xfer_req;
        r_xfer_data <= send_data;
        r_cnt       <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign xfer_req  = r_xfer_req;
  assign xfer_data = r_xfer_data;
  assign done      = r_done;
  assign timeout   = r_timeout;

endmodule
